// File: rtl/qed_prog_loader.sv
// Program loader: packs a word stream into imem lines, then writes dmem words.
// Define LOADER_CHECKSUM_EN to add exp_sum/sum_err and a running sum of accepted words.
module qed_prog_loader #(
   parameter int unsigned DATA_LEN   = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned IMEM_AW    = 9,
   parameter int unsigned DMEM_AW    = 30,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [CNT_W-1:0]               imem_lines,
   input  logic [CNT_W-1:0]               dmem_words,
   input  logic [DATA_LEN-1:0]            in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic                           imem_we,
   output logic [IMEM_AW-1:0]             imem_addr,
   output logic [LINE_WORDS*DATA_LEN-1:0] imem_wdata,
   output logic                           dmem_we,
   output logic [DMEM_AW-1:0]             dmem_addr,
   output logic [DATA_LEN-1:0]            dmem_wdata,
   output logic                           prog_loading,
   output logic                           done
`ifdef LOADER_CHECKSUM_EN
   ,
   input  logic [DATA_LEN-1:0]            exp_sum,
   output logic                           sum_err
`endif
);

   localparam int unsigned SLOT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int unsigned LINE_W = LINE_WORDS * DATA_LEN;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LINE_WORDS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD_I = 2'd1;
   localparam logic [1:0] S_LOAD_D = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    lines_left_q, lines_left_d;
   logic [CNT_W-1:0]    words_left_q, words_left_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [SLOT_W-1:0]   slot_rev;
   logic [LINE_W-1:0]   pack_q, pack_d;
   logic [IMEM_AW-1:0]  line_ptr_q, line_ptr_d;
   logic [DMEM_AW-1:0]  word_ptr_q, word_ptr_d;
   logic                imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
   logic [LINE_W-1:0]   imem_wdata_q, imem_wdata_d;
   logic                dmem_we_q, dmem_we_d;
   logic [DMEM_AW-1:0]  dmem_addr_q, dmem_addr_d;
   logic [DATA_LEN-1:0] dmem_wdata_q, dmem_wdata_d;
   logic                accept;
   logic                start_ok;

   // A zero remaining-count inside a LOAD state is a one-cycle drain so that
   // done rises only after the final write strobe has been issued.
   always_comb begin
      in_ready = ((state_q == S_LOAD_I) && (lines_left_q != '0)) ||
                 ((state_q == S_LOAD_D) && (words_left_q != '0));
   end

   always_comb begin
      accept   = in_valid && in_ready;
      start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
      slot_rev = SLOT_LAST - slot_q;
   end

   always_comb begin
      state_d      = state_q;
      lines_left_d = lines_left_q;
      words_left_d = words_left_q;
      slot_d       = slot_q;
      pack_d       = pack_q;
      line_ptr_d   = line_ptr_q;
      word_ptr_d   = word_ptr_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      dmem_we_d    = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               lines_left_d = imem_lines;
               words_left_d = dmem_words;
               slot_d       = '0;
               pack_d       = '0;
               line_ptr_d   = '0;
               word_ptr_d   = '0;
               imem_addr_d  = '0;
               dmem_addr_d  = '0;
               if (imem_lines != '0) begin
                  state_d = S_LOAD_I;
               end else if (dmem_words != '0) begin
                  state_d = S_LOAD_D;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_LOAD_I: begin
            if (lines_left_q == '0) begin
               state_d = S_DONE;
            end else if (accept) begin
               // First word of a line lands in the most significant slot.
               pack_d[slot_rev*DATA_LEN +: DATA_LEN] = in_data;
               if (slot_q == SLOT_LAST) begin
                  slot_d       = '0;
                  imem_we_d    = 1'b1;
                  imem_addr_d  = line_ptr_q;
                  imem_wdata_d = pack_d;
                  pack_d       = '0;
                  line_ptr_d   = line_ptr_q + IMEM_AW'(1);
                  lines_left_d = lines_left_q - CNT_W'(1);
                  if ((lines_left_q == CNT_W'(1)) && (words_left_q != '0)) begin
                     state_d = S_LOAD_D;
                  end
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end

         S_LOAD_D: begin
            if (words_left_q == '0) begin
               state_d = S_DONE;
            end else if (accept) begin
               dmem_we_d    = 1'b1;
               dmem_addr_d  = word_ptr_q;
               dmem_wdata_d = in_data;
               word_ptr_d   = word_ptr_q + DMEM_AW'(1);
               words_left_d = words_left_q - CNT_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         lines_left_q <= '0;
         words_left_q <= '0;
         slot_q       <= '0;
         pack_q       <= '0;
         line_ptr_q   <= '0;
         word_ptr_q   <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         lines_left_q <= lines_left_d;
         words_left_q <= words_left_d;
         slot_q       <= slot_d;
         pack_q       <= pack_d;
         line_ptr_q   <= line_ptr_d;
         word_ptr_q   <= word_ptr_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign prog_loading = (state_q != S_DONE);
   assign done         = (state_q == S_DONE);

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_LEN-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (start_ok) begin
         sum_d = '0;
      end else if (accept) begin
         sum_d = sum_q + in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_err = (state_q == S_DONE) && (sum_q != exp_sum);
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: doc/qed_prog_loader.md
QED_PROG_LOADER -- requirements
Module: qed_prog_loader

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be honoured as stated:
- DATA_LEN, 32, stream and dmem word width.
- LINE_WORDS, 4, words packed per imem line (power of two, >=1).
- IMEM_AW, 9, imem line address width.
- DMEM_AW, 30, dmem word address width.
- CNT_W, 16, width of the length counters.
REQ-002 Ports (name, direction, width, meaning); each SHALL exist as listed:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high reset.
- start, in, 1, begin a load session.
- imem_lines, in, CNT_W, number of imem lines to load; latched on an accepted start.
- dmem_words, in, CNT_W, number of dmem words to load; latched on an accepted start.
- in_data, in, DATA_LEN, program stream word.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, loader accepts the word this cycle.
- imem_we, out, 1, imem line write strobe.
- imem_addr, out, IMEM_AW, imem line address.
- imem_wdata, out, LINE_WORDS*DATA_LEN, packed line.
- dmem_we, out, 1, dmem write strobe.
- dmem_addr, out, DMEM_AW, dmem word address.
- dmem_wdata, out, DATA_LEN, dmem word.
- prog_loading, out, 1, core is held and memories are muxed to the loader.
- done, out, 1, session complete.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL implement FSM states IDLE, LOAD_I, LOAD_D and DONE.
REQ-005 A word SHALL be accepted exactly on a cycle where in_valid and in_ready are both 1.
REQ-006 in_ready SHALL be 1 only in LOAD_I or LOAD_D, and 0 in IDLE and DONE.
REQ-007 In IDLE or DONE, start=1 SHALL latch both counts, clear done, and branch on the latched counts: imem_lines!=0 -> LOAD_I; else dmem_words!=0 -> LOAD_D; else -> DONE.
REQ-008 start SHALL be ignored in LOAD_I and LOAD_D.
REQ-009 In LOAD_I, the k-th accepted word of a line (k=0..LINE_WORDS-1) SHALL be placed at slot LINE_WORDS-1-k, so the first word lands in the most significant DATA_LEN bits.
REQ-010 On acceptance of the last word of a line, imem_we SHALL pulse high for exactly the next cycle, with imem_addr equal to the line index (from 0, wrapping at 2^IMEM_AW) and imem_wdata equal to the packed line.
REQ-011 After the last line is accepted, the FSM SHALL go to LOAD_D if dmem_words!=0, else to DONE.
REQ-012 In LOAD_D, each accepted word SHALL produce dmem_we=1 on the next cycle, with dmem_wdata equal to the word and dmem_addr equal to the word index (from 0, wrapping at 2^DMEM_AW).
REQ-013 After the last dmem word is accepted, the FSM SHALL go to DONE.
REQ-014 Write strobes SHALL never be asserted in any other cycle; imem_we and dmem_we SHALL never both be 1.
REQ-015 prog_loading SHALL be 1 in IDLE, LOAD_I and LOAD_D.
REQ-016 prog_loading SHALL be 0 and done SHALL be 1 in DONE, starting the cycle after the final write strobe.
REQ-017 start=1 in DONE SHALL re-enter loading on the next cycle, with prog_loading=1 and addresses restarted at 0.
REQ-018 Stalls (in_valid=0) SHALL not alter packing, addresses or counts.

Reset
REQ-019 reset=1 SHALL force, on the next clk edge: state IDLE, prog_loading=1, done=0, in_ready=0, imem_we=0, dmem_we=0, all addresses, packed data and counters 0.
REQ-020 A reset asserted mid-session SHALL abort the session; a partially packed line SHALL be discarded and never written.

Configuration
REQ-021 With macro LOADER_CHECKSUM_EN defined, the block SHALL add input exp_sum (DATA_LEN) and output sum_err (1).
REQ-022 With LOADER_CHECKSUM_EN defined, the block SHALL keep a running sum of all accepted words modulo 2^DATA_LEN, cleared on reset and on an accepted start.
REQ-023 With LOADER_CHECKSUM_EN defined, sum_err SHALL be (sum != exp_sum) while in DONE, and 0 otherwise.
REQ-024 Without LOADER_CHECKSUM_EN, the block SHALL have neither port nor any summing logic.

Verification
REQ-025 Bench SHALL drive start, imem_lines=1, dmem_words=0, words 0xA,0xB,0xC,0xD -> one imem_we, addr 0, wdata 0x0000000A_0000000B_0000000C_0000000D, then done=1, prog_loading=0.
REQ-026 Bench SHALL drive imem_lines=2, dmem_words=2 with in_valid toggling every cycle -> two imem writes at addr 0,1, then dmem_we at addr 0,1 with the 9th and 10th words.
REQ-027 Bench SHALL drive start with both counts 0 -> DONE on the next cycle, no write strobes.
REQ-028 Bench SHALL assert reset after 2 of 4 words of a line -> no imem_we, prog_loading=1, state IDLE.
REQ-029 Bench SHALL assert start during LOAD_D -> ignored; counts and addresses unchanged.
REQ-030 Bench SHALL, with LOADER_CHECKSUM_EN, load words 1,2,3,4 with exp_sum=10 -> sum_err=0; with exp_sum=11 -> sum_err=1 in DONE.
